// File: rtl/modulo_contador_sync_4_bits_descendente_pkg.sv
// Shared constants and state encoding for the 4-bit descending timer counter.
package modulo_contador_sync_4_bits_descendente_pkg;

    localparam int LARGURA = 4;

    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        CONTANDO = 2'b01,
        FIM      = 2'b10
    } estado_t;

endpackage

// File: rtl/modulo_contador_sync_4_bits_descendente_ff_t.sv
// T flip-flop cell (modulo_ff_t): async active-low clear (dominant) and preset.
module modulo_ff_t (
    input  logic clock,
    input  logic clear,
    input  logic preset,
    input  logic t,
    output logic q
);

    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clock or negedge clear or negedge preset) begin
        if (!clear) begin
            q <= 1'b0;
        end else if (!preset) begin
            q <= 1'b1;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/modulo_contador_sync_4_bits_descendente.sv
// 4-bit synchronous down-counter with load, enable, zero/borrow and fim pulse.
// Define CONTADOR_AUTO_RECARGA_EN to reload from the last loaded value instead of stopping at 0.
module modulo_contador_sync_4_bits_descendente
    import modulo_contador_sync_4_bits_descendente_pkg::*;
(
    input  logic               clock,
    input  logic               clear,
    input  logic               carregar,
    input  logic [LARGURA-1:0] d,
    input  logic               habilitar,
    output logic [LARGURA-1:0] q,
    output logic               zero,
    output logic               emprestimo,
    output logic               fim,
    output logic               ocupado
);

    logic [LARGURA-1:0] w_q;
    logic [LARGURA-1:0] w_t;
    logic               w_q_zero;
    logic               w_decrementa;
    logic               w_fim_prox;
    estado_t            w_prox_estado;

    estado_t            r_estado;
    logic               r_fim;
    logic               r_ocupado;
`ifdef CONTADOR_AUTO_RECARGA_EN
    logic [LARGURA-1:0] r_recarga;
`endif

    assign w_q_zero     = (w_q == '0);
    assign w_decrementa = (r_estado == CONTANDO) && habilitar && !carregar;

    // Loads and reloads reach the T cells as q ^ target; plain counting uses
    // the borrow chain (a bit toggles when every lower bit is 0).
    always_comb begin
        logic v_baixos_zero;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_t           = '0;
        v_baixos_zero = 1'b1;
        if (carregar) begin
            w_t = w_q ^ d;
`ifdef CONTADOR_AUTO_RECARGA_EN
        end else if (w_decrementa && w_q_zero) begin
            w_t = w_q ^ r_recarga;
`endif
        end else if (w_decrementa && !w_q_zero) begin
            for (int i = 0; i < LARGURA; i++) begin
                w_t[i]        = v_baixos_zero;
                v_baixos_zero = v_baixos_zero & ~w_q[i];
            end
        end
    end

    always_comb begin
        w_prox_estado = r_estado;
        w_fim_prox    = 1'b0;
        if (carregar) begin
            w_prox_estado = (d != '0) ? CONTANDO : OCIOSO;
        end else if (w_decrementa && (w_q == LARGURA'(1))) begin
            w_fim_prox = 1'b1;
`ifndef CONTADOR_AUTO_RECARGA_EN
            w_prox_estado = FIM;
`endif
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_estado  <= OCIOSO;
            r_fim     <= 1'b0;
            r_ocupado <= 1'b0;
        end else begin
            r_estado  <= w_prox_estado;
            r_fim     <= w_fim_prox;
            r_ocupado <= (w_prox_estado == CONTANDO);
        end
    end

`ifdef CONTADOR_AUTO_RECARGA_EN
    // The reload value only matters when the counter wraps back to it.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_recarga <= '0;
        end else if (carregar) begin
            r_recarga <= d;
        end
    end
`endif

    for (genvar i = 0; i < LARGURA; i++) begin : g_bit
        modulo_ff_t u_ff (
            .clock  (clock),
            .clear  (clear),
            .preset (1'b1),
            .t      (w_t[i]),
            .q      (w_q[i])
        );
    end

    assign q          = w_q;
    assign zero       = w_q_zero;
    assign emprestimo = habilitar & w_q_zero;
    assign fim        = r_fim;
    assign ocupado    = r_ocupado;

endmodule

// File: tb/tb_modulo_contador_sync_4_bits_descendente.sv
// Scoreboard bench for the descending counter: stimulus pushes expectations, a monitor pops and compares.
module tb_modulo_contador_sync_4_bits_descendente;

`ifdef CONTADOR_AUTO_RECARGA_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic       carregar = 1'b0;
    logic [3:0] d = 4'd0;
    logic       habilitar = 1'b0;
    logic [3:0] q;
    logic       zero, emprestimo, fim, ocupado;

    always #5 clock = ~clock;

    modulo_contador_sync_4_bits_descendente dut (
        .clock      (clock),
        .clear      (clear),
        .carregar   (carregar),
        .d          (d),
        .habilitar  (habilitar),
        .q          (q),
        .zero       (zero),
        .emprestimo (emprestimo),
        .fim        (fim),
        .ocupado    (ocupado)
    );

    typedef struct {
        logic [3:0] q;
        logic       zero;
        logic       emprestimo;
        logic       fim;
        logic       ocupado;
        string      nome;
    } esperado_t;

    esperado_t fila[$];
    event      e_amostra;
    int        n_vet = 0;
    int        n_err = 0;

    // Reference model: count value, whether a count is in progress, pulse flag.
    int m_q       = 0;
    bit m_busy    = 1'b0;
    bit m_fim     = 1'b0;
    int m_recarga = 0;

    task automatic check(input esperado_t e);
        n_vet++;
        if (q !== e.q || zero !== e.zero || emprestimo !== e.emprestimo ||
            fim !== e.fim || ocupado !== e.ocupado) begin
            n_err++;
            $display("FAIL %s: got q=%0d zero=%b emp=%b fim=%b ocup=%b, expected q=%0d zero=%b emp=%b fim=%b ocup=%b",
                     e.nome, q, zero, emprestimo, fim, ocupado,
                     e.q, e.zero, e.emprestimo, e.fim, e.ocupado);
        end
    endtask

    function automatic esperado_t observa(input string nome);
        esperado_t e;
        e.q          = 4'(m_q);
        e.zero       = (m_q == 0);
        e.emprestimo = habilitar && (m_q == 0);
        e.fim        = m_fim;
        e.ocupado    = m_busy;
        e.nome       = nome;
        return e;
    endfunction

    task automatic ciclo(input logic c_clear, input logic c_car, input logic [3:0] c_d,
                         input logic c_hab, input string nome);
        @(negedge clock);
        clear     = c_clear;
        carregar  = c_car;
        d         = c_d;
        habilitar = c_hab;
        if (!c_clear) begin
            m_q = 0; m_busy = 1'b0; m_fim = 1'b0; m_recarga = 0;
        end
        fila.push_back(observa({nome, "/imediato"}));
        ->e_amostra;
        if (c_clear) begin
            m_fim = 1'b0;
            if (c_car) begin
                m_q       = int'(c_d);
                m_recarga = int'(c_d);
                m_busy    = (c_d != 4'd0);
            end else if (m_busy && c_hab) begin
                if (m_q == 0) begin
                    m_q = m_recarga;
                end else begin
                    m_q = m_q - 1;
                    if (m_q == 0) begin
                        m_fim = 1'b1;
                        if (!AUTO) m_busy = 1'b0;
                    end
                end
            end
        end
        fila.push_back(observa({nome, "/borda"}));
    endtask

    initial begin
        forever begin
            @(posedge clock or e_amostra);
            #1;
            if (fila.size() > 0) check(fila.pop_front());
        end
    end

    initial begin
        ciclo(0, 0, 4'd0, 0, "reset");
        ciclo(0, 0, 4'd0, 1, "reset_hab");
        ciclo(1, 1, 4'd5, 0, "carga5");
        ciclo(0, 0, 4'd0, 1, "reset_meio");
        ciclo(1, 0, 4'd0, 1, "pos_reset");

        ciclo(1, 1, 4'd3, 1, "carga3");
        repeat (8) ciclo(1, 0, 4'd0, 1, "conta3");

        ciclo(1, 1, 4'd9, 0, "carga9");
        repeat (2) ciclo(1, 0, 4'd0, 1, "hab9");
        repeat (3) ciclo(1, 0, 4'd0, 0, "para9");

        ciclo(1, 1, 4'd4, 0, "carga4");
        ciclo(1, 1, 4'd12, 1, "carga_sim");
        repeat (3) ciclo(1, 0, 4'd0, 1, "conta12");

        ciclo(1, 1, 4'd1, 1, "carga1");
        ciclo(1, 1, 4'd7, 1, "carga_no_zero");
        ciclo(1, 1, 4'd0, 1, "carga0");
        ciclo(1, 0, 4'd0, 1, "zero_hab");
        ciclo(1, 0, 4'd0, 0, "zero_sem_hab");

        repeat (600) begin
            ciclo(($urandom_range(0, 59) != 0), ($urandom_range(0, 9) == 0),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), "aleatorio");
        end

        repeat (2) @(negedge clock);
        if (fila.size() != 0) begin
            n_vet++;
            n_err++;
            $display("FAIL fila: got %0d pending expectations, expected 0", fila.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vet, n_err);
        $finish;
    end

endmodule
